// File: rtl/reg_space_if.sv
// Bus bundle for reg_space_arbiter: TWP word-request port and cfg req/rdy host port.
// slave = the register-space arbiter, master = whatever drives TWP requests and cfg accesses.
interface reg_space_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    // twp_valid: single-cycle request pulse, never stalled (no ready); twp_rvalid answers reads.
    // cfg: cfg_req held with cmd/addr/wdata until cfg_rdy=1, then dropped; cfg_rdy falls after.
    logic          twp_valid;
    logic          twp_cmd;
    logic [AW-1:0] twp_addr;
    logic [DW-1:0] twp_wdata;
    logic          twp_rvalid;
    logic [DW-1:0] twp_rdata;
    logic          twp_ovf;
    logic          twp_err;
    logic          cfg_req;
    logic          cfg_cmd;
    logic [AW-1:0] cfg_addr;
    logic [DW-1:0] cfg_wdata;
    logic          cfg_rdy;
    logic [DW-1:0] cfg_rdata;

    modport slave (
        input  twp_valid, twp_cmd, twp_addr, twp_wdata,
        output twp_rvalid, twp_rdata, twp_ovf, twp_err,
        input  cfg_req, cfg_cmd, cfg_addr, cfg_wdata,
        output cfg_rdy, cfg_rdata
    );

    modport master (
        output twp_valid, twp_cmd, twp_addr, twp_wdata,
        input  twp_rvalid, twp_rdata, twp_ovf, twp_err,
        output cfg_req, cfg_cmd, cfg_addr, cfg_wdata,
        input  cfg_rdy, cfg_rdata
    );
endinterface

// File: rtl/reg_space_arbiter.sv
// 2**AW x DW register space shared by the TWP deserializer and the cfg host, one access per cycle.
// Define REGARB_WPROT_EN to make TWP writes below PROT_TOP drop with a twp_err pulse.
module reg_space_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 16,
    parameter int MAX_WAIT = 4,
    parameter int PROT_TOP = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    reg_space_if.slave bus,
    output logic [1:0] dbg_state
);
    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_PEND = 2'd1,
        C_DONE = 2'd2
    } cfg_state_t;

    localparam int         DEPTH    = 1 << AW;
    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);
    localparam logic [AW:0] PROT_LIM = (AW + 1)'(PROT_TOP);
`ifdef REGARB_WPROT_EN
    localparam bit WPROT_ON = 1'b1;
`else
    localparam bit WPROT_ON = 1'b0;
`endif

    cfg_state_t    state, state_nx;
    logic [3:0]    cfg_wait;
    logic          pend_v, b_cmd;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic          c_cmd;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;
    logic          grant_twp, grant_cfg, twp_blocked;
    logic [DW-1:0] mem [DEPTH];

    // TWP wins unless cfg has already waited MAX_WAIT cycles.
    always_comb begin
        grant_twp   = pend_v && !(state == C_PEND && cfg_wait == WAIT_MAX);
        grant_cfg   = !grant_twp && (state == C_PEND);
        twp_blocked = WPROT_ON && b_cmd && ({1'b0, b_addr} < PROT_LIM);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= C_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            C_IDLE:  if (bus.cfg_req && !bus.cfg_rdy) state_nx = C_PEND;
            C_PEND:  if (grant_cfg) state_nx = C_DONE;
            C_DONE:  if (!bus.cfg_req) state_nx = C_IDLE;
            default: state_nx = C_IDLE;
        endcase
    end

    always_comb begin
        bus.cfg_rdy = (state == C_DONE);
        dbg_state   = state;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c_cmd    <= 1'b0;
            c_addr   <= '0;
            c_wdata  <= '0;
            cfg_wait <= '0;
        end else begin
            if (state == C_IDLE && state_nx == C_PEND) begin
                c_cmd   <= bus.cfg_cmd;
                c_addr  <= bus.cfg_addr;
                c_wdata <= bus.cfg_wdata;
            end
            if (grant_cfg)
                cfg_wait <= '0;
            else if (state == C_PEND && cfg_wait != WAIT_MAX)
                cfg_wait <= cfg_wait + 4'd1;
        end
    end

    // 1-deep TWP buffer; it may reload in the same cycle it is served.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_v      <= 1'b0;
            b_cmd       <= 1'b0;
            b_addr      <= '0;
            b_wdata     <= '0;
            bus.twp_ovf <= 1'b0;
        end else if (bus.twp_valid && (!pend_v || grant_twp)) begin
            pend_v  <= 1'b1;
            b_cmd   <= bus.twp_cmd;
            b_addr  <= bus.twp_addr;
            b_wdata <= bus.twp_wdata;
        end else begin
            if (grant_twp)     pend_v      <= 1'b0;
            if (bus.twp_valid) bus.twp_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (grant_twp && b_cmd && !twp_blocked)
            mem[b_addr] <= b_wdata;
        else if (grant_cfg && c_cmd)
            mem[c_addr] <= c_wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.twp_rvalid <= 1'b0;
            bus.twp_rdata  <= '0;
            bus.twp_err    <= 1'b0;
            bus.cfg_rdata  <= '0;
        end else begin
            bus.twp_rvalid <= grant_twp && !b_cmd;
            bus.twp_err    <= grant_twp && twp_blocked;
            if (grant_twp && !b_cmd) bus.twp_rdata <= mem[b_addr];
            if (grant_cfg && !c_cmd) bus.cfg_rdata <= mem[c_addr];
        end
    end
endmodule

// File: tb/tb_reg_space_arbiter.sv
// Directed bench for reg_space_arbiter: cfg/TWP accesses, priority, starvation guard, protection, reset.
module tb_reg_space_arbiter;
    localparam int AW = 8;
    localparam int DW = 16;
`ifdef REGARB_WPROT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [1:0]    dbg_state;
    int            n_pass = 0;
    int            n_total = 0;
    int            rvalid_seen = 0;
    logic [DW-1:0] exp_q[$];

    reg_space_if #(.AW(AW), .DW(DW)) bus();

    reg_space_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4), .PROT_TOP(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got running, expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // scoreboard for TWP read returns
    always @(negedge clk) begin
        if (reset_n && bus.twp_rvalid) begin
            rvalid_seen++;
            if (exp_q.size() > 0) check("twp_rdata_sb", bus.twp_rdata, exp_q.pop_front());
            else check("twp_rvalid_spurious", 1, 0);
        end
    end

    // drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic twp_pulse(input logic cmd, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        bus.twp_valid = 1'b1;
        bus.twp_cmd   = cmd;
        bus.twp_addr  = addr;
        bus.twp_wdata = wdata;
        tick();
        bus.twp_valid = 1'b0;
    endtask

    task automatic cfg_start(input logic cmd, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        bus.cfg_req   = 1'b1;
        bus.cfg_cmd   = cmd;
        bus.cfg_addr  = addr;
        bus.cfg_wdata = wdata;
    endtask

    task automatic cfg_access(input string tag, input logic cmd, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata, input int exp_lat, input logic [DW-1:0] exp_rdata);
        int lat;
        lat = 0;
        cfg_start(cmd, addr, wdata);
        do begin
            tick();
            lat++;
            bus.twp_valid = 1'b0;
        end while (!bus.cfg_rdy && lat < 20);
        check({tag, "_lat"}, lat, exp_lat);
        if (!cmd) check({tag, "_rdata"}, bus.cfg_rdata, exp_rdata);
        bus.cfg_req = 1'b0;
        tick();
        check({tag, "_rdy_drop"}, bus.cfg_rdy, 0);
    endtask

    initial begin
        bus.twp_valid = 1'b0; bus.twp_cmd = 1'b0; bus.twp_addr = '0; bus.twp_wdata = '0;
        bus.cfg_req = 1'b0; bus.cfg_cmd = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;

        repeat (2) tick();
        check("rst_twp_rvalid", bus.twp_rvalid, 0);
        check("rst_twp_rdata", bus.twp_rdata, 0);
        check("rst_twp_ovf", bus.twp_ovf, 0);
        check("rst_twp_err", bus.twp_err, 0);
        check("rst_cfg_rdy", bus.cfg_rdy, 0);
        check("rst_cfg_rdata", bus.cfg_rdata, 0);
        check("rst_state", dbg_state, 0);
        reset_n = 1'b1;
        tick();

        cfg_access("cfg_wr_12", 1'b1, 8'h12, 16'hBEEF, 2, 16'h0);
        cfg_access("cfg_rd_12", 1'b0, 8'h12, 16'h0, 2, 16'hBEEF);

        twp_pulse(1'b1, 8'h40, 16'h1234);
        tick();
        exp_q.push_back(16'h1234);
        twp_pulse(1'b0, 8'h40, 16'h0);
        check("twp_rvalid_early", bus.twp_rvalid, 0);
        tick();
        check("twp_rvalid_pulse", bus.twp_rvalid, 1);
        check("twp_rdata_40", bus.twp_rdata, 16'h1234);
        tick();
        check("twp_rvalid_fall", bus.twp_rvalid, 0);

        // TWP and cfg arrive together: TWP write goes first, cfg read sees it
        bus.twp_valid = 1'b1; bus.twp_cmd = 1'b1; bus.twp_addr = 8'h05; bus.twp_wdata = 16'hAAAA;
        cfg_access("same_cycle", 1'b0, 8'h05, 16'h0, 3, 16'hAAAA);

        // buffer kept full: cfg granted after MAX_WAIT waits, one TWP request dropped
        cfg_start(1'b0, 8'h12, 16'h0);
        for (int k = 0; k < 6; k++) begin
            bus.twp_valid = 1'b1; bus.twp_cmd = 1'b1; bus.twp_addr = 8'h80;
            bus.twp_wdata = 16'(16'h1000 + k);
            if (k == 5) begin
                check("starve_rdy_early", bus.cfg_rdy, 0);
                check("starve_ovf_early", bus.twp_ovf, 0);
                check("starve_state_pend", dbg_state, 1);
            end
            tick();
        end
        bus.twp_valid = 1'b0;
        check("starve_rdy", bus.cfg_rdy, 1);
        check("starve_rdata", bus.cfg_rdata, 16'hBEEF);
        check("starve_ovf", bus.twp_ovf, 1);
        bus.cfg_req = 1'b0;
        repeat (4) tick();
        check("ovf_sticky", bus.twp_ovf, 1);
        cfg_access("rd_80", 1'b0, 8'h80, 16'h0, 2, 16'h1004);

        // write protection boundary cases
        cfg_access("wr_03", 1'b1, 8'h03, 16'h0001, 2, 16'h0);
        twp_pulse(1'b1, 8'h03, 16'hFFFF);
        check("err_03_capture", bus.twp_err, 0);
        tick();
        check("err_03_pulse", bus.twp_err, PROT);
        tick();
        check("err_03_fall", bus.twp_err, 0);
        cfg_access("rd_03", 1'b0, 8'h03, 16'h0, 2, PROT ? 16'h0001 : 16'hFFFF);
        twp_pulse(1'b1, 8'h20, 16'hFFFF);
        tick();
        check("err_20_none", bus.twp_err, 0);
        tick();
        cfg_access("rd_20", 1'b0, 8'h20, 16'h0, 2, 16'hFFFF);

        // reset while a cfg write is pending
        cfg_start(1'b1, 8'h12, 16'h5555);
        tick();
        check("rst_mid_pend", dbg_state, 1);
        reset_n = 1'b0;
        #1;
        check("rst_mid_rdy", bus.cfg_rdy, 0);
        check("rst_mid_state", dbg_state, 0);
        check("rst_mid_ovf", bus.twp_ovf, 0);
        bus.cfg_req = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        cfg_access("rd_12_after_rst", 1'b0, 8'h12, 16'h0, 2, 16'hBEEF);

        tick();
        check("sb_queue_empty", exp_q.size(), 0);
        check("sb_rvalid_count", rvalid_seen, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
